// File: rtl/qpsk_symbol_serializer_pkg.sv
// Shared definitions for the QPSK symbol serializer: widths, frame size,
// nominal constellation amplitude and the controller state encoding.
package qpsk_pkg;

   localparam int SYM_W_DEF = 16;
   localparam int NUM_SYM   = 4;

   // 1/sqrt(2) in Q2.14, the per-axis amplitude of a unit-energy QPSK point
   localparam logic signed [15:0] QPSK_AMP = 16'sd11585;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   function automatic logic [7:0] sps_last(input int sps);
      return 8'(sps - 1);
   endfunction

endpackage

// File: rtl/qpsk_symbol_serializer_if.sv
// Frame-in / sample-out handshake bundle of the QPSK symbol serializer.
interface qpsk_symbol_serializer_if
   import qpsk_pkg::*;
#(
   parameter int SYM_W = SYM_W_DEF
);

   logic             in_valid;
   logic             in_ready;
   logic [SYM_W-1:0] symb_real_1;
   logic [SYM_W-1:0] symb_real_2;
   logic [SYM_W-1:0] symb_real_3;
   logic [SYM_W-1:0] symb_real_4;
   logic [SYM_W-1:0] symb_imag_1;
   logic [SYM_W-1:0] symb_imag_2;
   logic [SYM_W-1:0] symb_imag_3;
   logic [SYM_W-1:0] symb_imag_4;
   logic             out_valid;
   logic             out_ready;
   logic [SYM_W-1:0] out_real;
   logic [SYM_W-1:0] out_imag;
   logic             out_first;
   logic             out_last;
   logic [7:0]       frame_cnt;

   modport master (
      output in_valid, symb_real_1, symb_real_2, symb_real_3, symb_real_4,
             symb_imag_1, symb_imag_2, symb_imag_3, symb_imag_4, out_ready,
      input  in_ready, out_valid, out_real, out_imag, out_first, out_last, frame_cnt
   );

   modport slave (
      input  in_valid, symb_real_1, symb_real_2, symb_real_3, symb_real_4,
             symb_imag_1, symb_imag_2, symb_imag_3, symb_imag_4, out_ready,
      output in_ready, out_valid, out_real, out_imag, out_first, out_last, frame_cnt
   );

endinterface

// File: rtl/qpsk_symbol_serializer.sv
// Serializes a four-symbol QPSK frame into SPS repeated I/Q samples per symbol
// with a valid/ready output stream and zero-bubble back-to-back frame loading.
module qpsk_symbol_serializer
   import qpsk_pkg::*;
#(
   parameter int SYM_W = SYM_W_DEF,
   parameter int SPS   = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   qpsk_symbol_serializer_if.slave  bus
);

   localparam logic [7:0] SAMP_LAST = sps_last(SPS);
   localparam logic [1:0] SYM_LAST  = 2'(NUM_SYM - 1);

   state_e           state_q,     state_d;
   logic [SYM_W-1:0] re_q [NUM_SYM];
   logic [SYM_W-1:0] re_d [NUM_SYM];
   logic [SYM_W-1:0] im_q [NUM_SYM];
   logic [SYM_W-1:0] im_d [NUM_SYM];
   logic [1:0]       sym_idx_q,   sym_idx_d;
   logic [7:0]       samp_cnt_q,  samp_cnt_d;
   logic [7:0]       frame_cnt_q, frame_cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [SYM_W-1:0] out_real_q,  out_real_d;
   logic [SYM_W-1:0] out_imag_q,  out_imag_d;
   logic             out_first_q, out_first_d;
   logic             out_last_q,  out_last_d;

   logic beat_s;
   logic in_ready_s;
   logic accept_s;
   logic samp_wrap_s;

   // out_last_q is only ever set in SEND, so this is the single out_ready->in_ready path
   assign beat_s      = out_valid_q & bus.out_ready;
   assign in_ready_s  = (state_q == IDLE) | (out_last_q & bus.out_ready);
   assign accept_s    = bus.in_valid & in_ready_s;
   assign samp_wrap_s = (samp_cnt_q == SAMP_LAST);

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_q;
   assign bus.out_real  = out_real_q;
   assign bus.out_imag  = out_imag_q;
   assign bus.out_first = out_first_q;
   assign bus.out_last  = out_last_q;
   assign bus.frame_cnt = frame_cnt_q;

   // Next-state, counter, frame-register and registered-output computation
   always_comb begin
      state_d    = state_q;
      re_d       = re_q;
      im_d       = im_q;
      sym_idx_d  = sym_idx_q;
      samp_cnt_d = samp_cnt_q;

      if (beat_s && out_last_q) begin
         frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
         frame_cnt_d = frame_cnt_q;
      end

      // A SEND-state accept always coincides with the final beat, so loading wins
      if (accept_s) begin
         re_d[0]    = bus.symb_real_1;
         re_d[1]    = bus.symb_real_2;
         re_d[2]    = bus.symb_real_3;
         re_d[3]    = bus.symb_real_4;
         im_d[0]    = bus.symb_imag_1;
         im_d[1]    = bus.symb_imag_2;
         im_d[2]    = bus.symb_imag_3;
         im_d[3]    = bus.symb_imag_4;
         sym_idx_d  = 2'd0;
         samp_cnt_d = 8'd0;
         state_d    = SEND;
      end else if (beat_s) begin
         if (samp_wrap_s) begin
            samp_cnt_d = 8'd0;
            if (sym_idx_q == SYM_LAST) begin
               sym_idx_d = 2'd0;
               state_d   = IDLE;
            end else begin
               sym_idx_d = sym_idx_q + 2'd1;
            end
         end else begin
            samp_cnt_d = samp_cnt_q + 8'd1;
         end
      end else begin
         state_d = state_q;
      end

      if (state_d == SEND) begin
         out_valid_d = 1'b1;
         out_real_d  = re_d[sym_idx_d];
         out_imag_d  = im_d[sym_idx_d];
         out_first_d = (sym_idx_d == 2'd0) && (samp_cnt_d == 8'd0);
         out_last_d  = (sym_idx_d == SYM_LAST) && (samp_cnt_d == SAMP_LAST);
      end else begin
         out_valid_d = 1'b0;
         out_real_d  = '0;
         out_imag_d  = '0;
         out_first_d = 1'b0;
         out_last_d  = 1'b0;
      end
   end

   // State and datapath registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         for (int i = 0; i < NUM_SYM; i++) begin
            re_q[i] <= '0;
            im_q[i] <= '0;
         end
         sym_idx_q   <= 2'd0;
         samp_cnt_q  <= 8'd0;
         frame_cnt_q <= 8'd0;
         out_valid_q <= 1'b0;
         out_real_q  <= '0;
         out_imag_q  <= '0;
         out_first_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         re_q        <= re_d;
         im_q        <= im_d;
         sym_idx_q   <= sym_idx_d;
         samp_cnt_q  <= samp_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         out_valid_q <= out_valid_d;
         out_real_q  <= out_real_d;
         out_imag_q  <= out_imag_d;
         out_first_q <= out_first_d;
         out_last_q  <= out_last_d;
      end
   end

endmodule

// File: tb/tb_qpsk_symbol_serializer.sv
// Self-checking bench: a queue of expected samples is built from each accepted
// frame and every output cycle is compared against it.
module tb_qpsk_symbol_serializer;
   import qpsk_pkg::*;

   localparam int W     = 16;
   localparam int SPS_A = 4;
   localparam int SPS_B = 1;

   localparam logic [15:0] AP = QPSK_AMP;
   localparam logic [15:0] AN = 16'(-QPSK_AMP);
   localparam logic [63:0] Q_RE = {AP, AN, AN, AP};
   localparam logic [63:0] Q_IM = {AP, AP, AN, AN};

   typedef struct packed {
      logic [15:0] re;
      logic [15:0] im;
      logic        sfirst;
      logic        slast;
   } samp_t;

   logic clk;
   logic rst_n;

   qpsk_symbol_serializer_if #(.SYM_W(W)) bus_a ();
   qpsk_symbol_serializer_if #(.SYM_W(W)) bus_b ();

   qpsk_symbol_serializer #(.SYM_W(W), .SPS(SPS_A)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   qpsk_symbol_serializer #(.SYM_W(W), .SPS(SPS_B)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   int          tests_run    = 0;
   int          tests_failed = 0;
   samp_t       exp_q[$];
   logic [7:0]  exp_fc;
   bit          mon_en;
   int          rdy_mode;
   int          beats_a;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: expected sample stream, in_ready and frame count for instance A
   initial begin
      bit          ev;
      bit          erdy;
      logic [15:0] fr[4];
      logic [15:0] fi[4];
      forever begin
         @(negedge clk);
         if (mon_en) begin
            ev   = (exp_q.size() != 0);
            erdy = !ev || (exp_q[0].slast && bus_a.out_ready);
            check_eq("out_valid", 32'(bus_a.out_valid), 32'(ev));
            check_eq("frame_cnt", 32'(bus_a.frame_cnt), 32'(exp_fc));
            check_eq("in_ready", 32'(bus_a.in_ready), 32'(erdy));
            if (ev) begin
               check_eq("out_real", 32'(bus_a.out_real), 32'(exp_q[0].re));
               check_eq("out_imag", 32'(bus_a.out_imag), 32'(exp_q[0].im));
               check_eq("out_first", 32'(bus_a.out_first), 32'(exp_q[0].sfirst));
               check_eq("out_last", 32'(bus_a.out_last), 32'(exp_q[0].slast));
               if (bus_a.out_ready) begin
                  if (exp_q[0].slast) exp_fc = exp_fc + 8'd1;
                  void'(exp_q.pop_front());
                  beats_a++;
               end
            end
            if (bus_a.in_valid && erdy) begin
               fr[0] = bus_a.symb_real_1; fr[1] = bus_a.symb_real_2;
               fr[2] = bus_a.symb_real_3; fr[3] = bus_a.symb_real_4;
               fi[0] = bus_a.symb_imag_1; fi[1] = bus_a.symb_imag_2;
               fi[2] = bus_a.symb_imag_3; fi[3] = bus_a.symb_imag_4;
               for (int s = 0; s < 4; s++) begin
                  for (int k = 0; k < SPS_A; k++) begin
                     exp_q.push_back('{re: fr[s], im: fi[s],
                                       sfirst: (s == 0 && k == 0),
                                       slast: (s == 3 && k == SPS_A - 1)});
                  end
               end
            end
         end
      end
   end

   // Downstream ready pattern for instance A
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: bus_a.out_ready = 1'b1;
            1: begin
               bus_a.out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
               ph++;
            end
            default: bus_a.out_ready = 1'($urandom_range(1, 0));
         endcase
      end
   end

   task automatic send_frame(input logic [63:0] rr, input logic [63:0] ii, input bit keep_valid);
      bit got;
      got = 1'b0;
      bus_a.symb_real_1 = rr[63:48]; bus_a.symb_real_2 = rr[47:32];
      bus_a.symb_real_3 = rr[31:16]; bus_a.symb_real_4 = rr[15:0];
      bus_a.symb_imag_1 = ii[63:48]; bus_a.symb_imag_2 = ii[47:32];
      bus_a.symb_imag_3 = ii[31:16]; bus_a.symb_imag_4 = ii[15:0];
      bus_a.in_valid = 1'b1;
      for (int c = 0; c < 400 && !got; c++) begin
         @(negedge clk);
         if (bus_a.in_ready) got = 1'b1;
      end
      check_eq("accept_timeout", 32'(got), 32'd1);
      @(posedge clk);
      #1;
      if (!keep_valid) bus_a.in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      bit done;
      done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0 && !bus_a.out_valid) done = 1'b1;
      end
      check_eq("idle_timeout", 32'(done), 32'd1);
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
      tests_failed++;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] b_re[4];
      logic [15:0] b_im[4];
      bit          keep;

      rst_n    = 1'b0;
      mon_en   = 1'b0;
      rdy_mode = 0;
      exp_fc   = 8'd0;
      beats_a  = 0;
      bus_a.in_valid  = 1'b0;
      bus_a.out_ready = 1'b1;
      bus_a.symb_real_1 = '0; bus_a.symb_real_2 = '0; bus_a.symb_real_3 = '0; bus_a.symb_real_4 = '0;
      bus_a.symb_imag_1 = '0; bus_a.symb_imag_2 = '0; bus_a.symb_imag_3 = '0; bus_a.symb_imag_4 = '0;
      bus_b.in_valid  = 1'b0;
      bus_b.out_ready = 1'b1;
      bus_b.symb_real_1 = '0; bus_b.symb_real_2 = '0; bus_b.symb_real_3 = '0; bus_b.symb_real_4 = '0;
      bus_b.symb_imag_1 = '0; bus_b.symb_imag_2 = '0; bus_b.symb_imag_3 = '0; bus_b.symb_imag_4 = '0;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
      check_eq("rst_out_real", 32'(bus_a.out_real), 32'd0);
      check_eq("rst_out_imag", 32'(bus_a.out_imag), 32'd0);
      check_eq("rst_out_first", 32'(bus_a.out_first), 32'd0);
      check_eq("rst_out_last", 32'(bus_a.out_last), 32'd0);
      check_eq("rst_frame_cnt", 32'(bus_a.frame_cnt), 32'd0);
      check_eq("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Single nominal QPSK frame
      beats_a = 0;
      send_frame(Q_RE, Q_IM, 1'b0);
      wait_idle(100);
      check_eq("t1_beats", 32'(beats_a), 32'd16);
      check_eq("t1_frame_cnt", 32'(bus_a.frame_cnt), 32'd1);

      // Two frames back-to-back with in_valid held
      beats_a = 0;
      send_frame(Q_RE, Q_IM, 1'b1);
      send_frame(rnd64(), rnd64(), 1'b0);
      wait_idle(100);
      check_eq("t2_beats", 32'(beats_a), 32'd32);
      check_eq("t2_frame_cnt", 32'(bus_a.frame_cnt), 32'd3);

      // Stalled output 1,0,0,1
      rdy_mode = 1;
      beats_a  = 0;
      send_frame(Q_RE, Q_IM, 1'b0);
      wait_idle(200);
      check_eq("t3_beats", 32'(beats_a), 32'd16);
      rdy_mode = 0;

      // Random frames, random backpressure and gaps
      rdy_mode = 2;
      for (int f = 0; f < 20; f++) begin
         keep = (f < 19) ? 1'($urandom_range(1, 0)) : 1'b0;
         send_frame(rnd64(), rnd64(), keep);
         if (!keep) repeat ($urandom_range(3, 0)) @(posedge clk);
         #1;
      end
      wait_idle(2000);
      rdy_mode = 0;
      @(posedge clk);
      #1;

      // Reset while the 7th sample is on the output
      send_frame(Q_RE, Q_IM, 1'b0);
      repeat (6) @(posedge clk);
      #2;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check_eq("mid_rst_out_valid", 32'(bus_a.out_valid), 32'd0);
      check_eq("mid_rst_out_real", 32'(bus_a.out_real), 32'd0);
      check_eq("mid_rst_out_imag", 32'(bus_a.out_imag), 32'd0);
      check_eq("mid_rst_out_first", 32'(bus_a.out_first), 32'd0);
      check_eq("mid_rst_out_last", 32'(bus_a.out_last), 32'd0);
      check_eq("mid_rst_frame_cnt", 32'(bus_a.frame_cnt), 32'd0);
      check_eq("mid_rst_in_ready", 32'(bus_a.in_ready), 32'd1);
      exp_q.delete();
      exp_fc = 8'd0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mon_en  = 1'b1;
      beats_a = 0;
      send_frame(Q_RE, Q_IM, 1'b0);
      wait_idle(100);
      check_eq("t5_beats", 32'(beats_a), 32'd16);
      check_eq("t5_frame_cnt", 32'(bus_a.frame_cnt), 32'd1);

      // 255 more frames: count wraps to zero
      for (int f = 0; f < 255; f++) begin
         send_frame(rnd64(), rnd64(), f < 254);
      end
      wait_idle(200);
      check_eq("wrap_frame_cnt", 32'(bus_a.frame_cnt), 32'd0);

      // SPS=1 instance: one beat per symbol
      b_re[0] = AP; b_re[1] = AN; b_re[2] = AN; b_re[3] = AP;
      b_im[0] = AN; b_im[1] = AP; b_im[2] = AN; b_im[3] = AP;
      bus_b.symb_real_1 = b_re[0]; bus_b.symb_real_2 = b_re[1];
      bus_b.symb_real_3 = b_re[2]; bus_b.symb_real_4 = b_re[3];
      bus_b.symb_imag_1 = b_im[0]; bus_b.symb_imag_2 = b_im[1];
      bus_b.symb_imag_3 = b_im[2]; bus_b.symb_imag_4 = b_im[3];
      bus_b.in_valid = 1'b1;
      @(negedge clk);
      check_eq("b_in_ready", 32'(bus_b.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus_b.in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_eq("b_out_valid", 32'(bus_b.out_valid), 32'd1);
         check_eq("b_out_real", 32'(bus_b.out_real), 32'(b_re[k]));
         check_eq("b_out_imag", 32'(bus_b.out_imag), 32'(b_im[k]));
         check_eq("b_out_first", 32'(bus_b.out_first), 32'(k == 0));
         check_eq("b_out_last", 32'(bus_b.out_last), 32'(k == 3));
      end
      @(negedge clk);
      check_eq("b_idle", 32'(bus_b.out_valid), 32'd0);
      check_eq("b_frame_cnt", 32'(bus_b.frame_cnt), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/qpsk_symbol_serializer.md
QPSK_SYMBOL_SERIALIZER -- requirements
Module: qpsk_symbol_serializer

Interface
REQ-001 SHALL have parameter SYM_W, default 16, meaning two's-complement width of each I/Q component.
REQ-002 SHALL have parameter SPS, default 4, meaning output samples per symbol; legal range 1..255.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, meaning a four-symbol frame is presented on the symb_* inputs.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts the frame this cycle.
REQ-007 SHALL have ports symb_real_1..4 and symb_imag_1..4, input, SYM_W each, meaning modulator symbols; symbol 1 is sent first.
REQ-008 SHALL have port out_valid, output, 1, meaning out_real/out_imag carry a valid sample.
REQ-009 SHALL have port out_ready, input, 1, meaning the downstream stage consumes the sample this cycle.
REQ-010 SHALL have ports out_real and out_imag, output, SYM_W each, meaning the current sample.
REQ-011 SHALL have port out_first, output, 1, meaning the current sample is the first sample of symbol 1.
REQ-012 SHALL have port out_last, output, 1, meaning the current sample is the last sample of symbol 4.
REQ-013 SHALL have port frame_cnt, output, 8, meaning the count of completed frames, wrapping 255->0.

Function
REQ-014 SHALL implement states IDLE and SEND; the reset state is IDLE.
REQ-015 In IDLE: in_ready=1, out_valid=0; in_valid=1 SHALL capture all eight inputs into the frame register, clear sym_idx and samp_cnt, and enter SEND on the next edge.
REQ-016 In SEND: out_valid=1; out_real/out_imag SHALL equal the registered symbol sym_idx, passed bit-exact with no scaling.
REQ-017 A beat (out_valid & out_ready) SHALL increment samp_cnt; at samp_cnt=SPS-1 it SHALL instead reset samp_cnt to 0 and increment sym_idx.
REQ-018 Without a beat, all outputs and counters SHALL hold (no sample dropped or repeated).
REQ-019 out_first SHALL be (SEND & sym_idx=0 & samp_cnt=0); out_last SHALL be (SEND & sym_idx=3 & samp_cnt=SPS-1).
REQ-020 A beat with out_last=1 SHALL increment frame_cnt (modulo 256).
REQ-021 In SEND, in_ready SHALL be (out_last & out_ready) combinationally; at most one combinational path runs from out_ready to in_ready.
REQ-022 A last beat with in_valid=1 SHALL load the new frame and stay in SEND with out_first on the next cycle (zero-bubble back-to-back).
REQ-023 A last beat with in_valid=0 SHALL return to IDLE.
REQ-024 First-sample latency SHALL be exactly 1 cycle from the accepting edge.
REQ-025 With SPS=1, each symbol SHALL occupy exactly one beat.
REQ-026 in_valid while in_ready=0 SHALL be ignored; the upstream holds the frame.

Reset
REQ-027 rst_n=0 SHALL asynchronously force: state=IDLE, frame register=0, sym_idx=0, samp_cnt=0, frame_cnt=0, out_valid=0, out_real=0, out_imag=0, out_first=0, out_last=0.
REQ-028 Reset mid-frame SHALL discard the partial frame without incrementing frame_cnt; after release the block SHALL be in IDLE with in_ready=1.

Structure
REQ-029 Shared package qpsk_pkg SHALL hold SYM_W default, NUM_SYM=4, the Q2.14 constant QPSK_AMP=11585, and the state encoding.
REQ-030 No sub-module is needed; the counters and frame register are inline.

Verification
REQ-031 Reset, then one frame of symbols (+11585,+11585),(-11585,+11585),(-11585,-11585),(+11585,-11585) with SPS=4 and out_ready=1 -> 16 beats, 4 per symbol in order, out_first on beat 1, out_last on beat 16, frame_cnt=1, return to IDLE.
REQ-032 Two frames back-to-back with in_valid held high -> 32 consecutive beats, no idle cycle, in_ready pulsed only on beat 16, frame_cnt=2.
REQ-033 out_ready toggled 1,0,0,1 repeatedly -> output sequence identical to REQ-031, outputs stable while out_ready=0.
REQ-034 SPS=1, frame 0x2D41/0xD2BF patterns -> 4 beats, out_first and out_last on beats 1 and 4.
REQ-035 rst_n asserted at beat 7 of a frame -> all outputs 0 within the same cycle, frame_cnt=0; a new frame after release starts with out_first.
REQ-036 256 frames sent -> frame_cnt wraps to 0.
